// File: rtl/microwave_timer_ctrl.sv
// Microwave cook-timer sequencer: keypad/door handling, 1 s countdown and
// registered drive of magnetron, lamp and buzzer. time_bin feeds the BCD display.
module microwave_timer_ctrl #(
   parameter int TICK_DIV   = 50000000,
   parameter int MAX_TIME   = 500,
   parameter int QUICK_TIME = 30,
   parameter int BEEP_SEC   = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       add_10s,
   input  logic       add_60s,
   input  logic       start,
   input  logic       stop,
   input  logic       door_open,
   output logic [8:0] time_bin,
   output logic       magnetron,
   output logic       lamp,
   output logic       buzzer,
   output logic [2:0] state_o
);

   localparam int TW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam int BW = (BEEP_SEC > 2) ? $clog2(BEEP_SEC) : 1;
   localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
   localparam logic [BW-1:0] BEEP_LAST = BW'(BEEP_SEC - 1);
   localparam logic [8:0]    MAX9      = 9'(MAX_TIME);
   localparam logic [8:0]    QUICK9    = 9'(QUICK_TIME);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      COOK  = 2'd1,
      PAUSE = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t          r_state;
   logic [8:0]      r_time;
   logic [TW-1:0]   r_tick_cnt;
   logic [BW-1:0]   r_beep_cnt;
   logic            r_magnetron;
   logic            r_lamp;
   logic            r_buzzer;

   logic            w_tick;
   logic            w_add_any;
   logic [9:0]      w_add_amt;
   logic [9:0]      w_base;
   logic [9:0]      w_sum;
   logic [8:0]      w_add_sat;
   logic [TW-1:0]   w_tick_adv;

   assign w_tick     = ((r_state == COOK) || (r_state == DONE)) && (r_tick_cnt == TICK_LAST);
   assign w_tick_adv = (r_tick_cnt == TICK_LAST) ? '0 : r_tick_cnt + 1'b1;
   assign w_add_any  = add_10s | add_60s;
   // +60 wins when both add keys arrive together
   assign w_add_amt  = add_60s ? 10'd60 : (add_10s ? 10'd10 : 10'd0);
   // A tick coinciding with an add folds the decrement into the sum
   assign w_base     = (w_tick && (r_state == COOK) && (r_time != 9'd0)) ?
                       ({1'b0, r_time} - 10'd1) : {1'b0, r_time};
   assign w_sum      = w_base + w_add_amt;
   assign w_add_sat  = (w_sum > {1'b0, MAX9}) ? MAX9 : w_sum[8:0];

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_time      <= '0;
         r_tick_cnt  <= '0;
         r_beep_cnt  <= '0;
         r_magnetron <= 1'b0;
         r_lamp      <= 1'b0;
         r_buzzer    <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               r_tick_cnt  <= '0;
               r_beep_cnt  <= '0;
               r_magnetron <= 1'b0;
               r_buzzer    <= 1'b0;
               r_lamp      <= door_open;
               if (door_open) begin
                  r_time <= r_time;
               end else if (stop) begin
                  r_time <= '0;
               end else if (start) begin
                  if (r_time == 9'd0) r_time <= QUICK9;
                  r_state     <= COOK;
                  r_magnetron <= 1'b1;
                  r_lamp      <= 1'b1;
               end else if (w_add_any) begin
                  r_time <= w_add_sat;
               end
            end

            COOK: begin
               r_lamp   <= 1'b1;
               r_buzzer <= 1'b0;
               if (door_open || stop) begin
                  r_state     <= PAUSE;
                  r_magnetron <= 1'b0;
               end else begin
                  r_magnetron <= 1'b1;
                  r_tick_cnt  <= w_tick_adv;
                  if (w_tick) begin
                     if (w_add_any) begin
                        r_time <= w_add_sat;
                     end else if (r_time <= 9'd1) begin
                        r_time      <= '0;
                        r_state     <= DONE;
                        r_beep_cnt  <= '0;
                        r_magnetron <= 1'b0;
                        r_lamp      <= 1'b0;
                        r_buzzer    <= 1'b1;
                     end else begin
                        r_time <= r_time - 9'd1;
                     end
                  end else if (w_add_any) begin
                     r_time <= w_add_sat;
                  end
               end
            end

            PAUSE: begin
               r_magnetron <= 1'b0;
               r_lamp      <= 1'b1;
               r_buzzer    <= 1'b0;
               if (door_open) begin
                  r_time <= r_time;
               end else if (stop) begin
                  r_time     <= '0;
                  r_state    <= IDLE;
                  r_tick_cnt <= '0;
                  r_lamp     <= door_open;
               end else if (start) begin
                  r_state     <= COOK;
                  r_magnetron <= 1'b1;
               end else if (w_add_any) begin
                  r_time <= w_add_sat;
               end
            end

            DONE: begin
               r_time      <= '0;
               r_magnetron <= 1'b0;
               if (door_open || stop) begin
                  r_state    <= IDLE;
                  r_tick_cnt <= '0;
                  r_beep_cnt <= '0;
                  r_buzzer   <= 1'b0;
                  r_lamp     <= door_open;
               end else begin
                  r_tick_cnt <= w_tick_adv;
                  r_buzzer   <= 1'b1;
                  r_lamp     <= 1'b0;
                  if (w_tick) begin
                     if (r_beep_cnt == BEEP_LAST) begin
                        r_state    <= IDLE;
                        r_beep_cnt <= '0;
                        r_tick_cnt <= '0;
                        r_buzzer   <= 1'b0;
                     end else begin
                        r_beep_cnt <= r_beep_cnt + 1'b1;
                     end
                  end
               end
            end

            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign time_bin  = r_time;
   assign magnetron = r_magnetron;
   assign lamp      = r_lamp;
   assign buzzer    = r_buzzer;
   assign state_o   = {1'b0, r_state};

endmodule

// File: tb/tb_microwave_timer_ctrl.sv
// Directed bench for microwave_timer_ctrl with TICK_DIV=4 (one tick every 4 cycles).
module tb_microwave_timer_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       add_10s, add_60s, start, stop, door_open;
   logic [8:0] time_bin;
   logic       magnetron, lamp, buzzer;
   logic [2:0] state_o;

   int checks   = 0;
   int failures = 0;

   microwave_timer_ctrl #(
      .TICK_DIV(4), .MAX_TIME(500), .QUICK_TIME(30), .BEEP_SEC(3)
   ) dut (
      .clk(clk), .rst(rst),
      .add_10s(add_10s), .add_60s(add_60s), .start(start), .stop(stop),
      .door_open(door_open),
      .time_bin(time_bin), .magnetron(magnetron), .lamp(lamp),
      .buzzer(buzzer), .state_o(state_o)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end else begin
         $display("chk %s = %0d", tag, act);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic pulse(input logic a10, input logic a60, input logic st, input logic sp);
      add_10s = a10; add_60s = a60; start = st; stop = sp;
      step();
      add_10s = 1'b0; add_60s = 1'b0; start = 1'b0; stop = 1'b0;
   endtask

   task automatic check_outs(input string tag, input int st, input int tm,
                             input int mg, input int lp, input int bz);
      check_val({tag, ".state"}, 32'(state_o), 32'(st));
      check_val({tag, ".time"}, 32'(time_bin), 32'(tm));
      check_val({tag, ".mag"}, 32'(magnetron), 32'(mg));
      check_val({tag, ".lamp"}, 32'(lamp), 32'(lp));
      check_val({tag, ".buzz"}, 32'(buzzer), 32'(bz));
   endtask

   initial begin
      rst = 1'b1;
      add_10s = 1'b0; add_60s = 1'b0; start = 1'b0; stop = 1'b0; door_open = 1'b0;
      steps(2);
      rst = 1'b0;
      check_outs("reset", 0, 0, 0, 0, 0);

      // keys in IDLE
      pulse(0, 1, 0, 0);
      pulse(1, 0, 0, 0);
      pulse(1, 0, 0, 0);
      check_outs("keys80", 0, 80, 0, 0, 0);
      pulse(1, 1, 0, 0);
      check_val("both_adds", 32'(time_bin), 32'd140);
      pulse(0, 0, 0, 1);
      check_val("idle_stop", 32'(time_bin), 32'd0);

      // quick start then cook down to done
      pulse(0, 0, 1, 0);
      check_outs("quick", 1, 30, 1, 1, 0);
      steps(108);
      check_val("cook_t3", 32'(time_bin), 32'd3);
      steps(4);
      check_val("cook_t2", 32'(time_bin), 32'd2);
      steps(4);
      check_val("cook_t1", 32'(time_bin), 32'd1);
      steps(3);
      check_val("cook_hold1", 32'(time_bin), 32'd1);
      check_val("cook_hold_st", 32'(state_o), 32'd1);
      steps(1);
      check_outs("done", 3, 0, 0, 0, 1);
      steps(11);
      check_val("beep_last_st", 32'(state_o), 32'd3);
      check_val("beep_last_bz", 32'(buzzer), 32'd1);
      steps(1);
      check_outs("beep_end", 0, 0, 0, 0, 0);

      // door interlock at 40 s
      for (int i = 0; i < 4; i++) pulse(1, 0, 0, 0);
      pulse(0, 0, 1, 0);
      check_outs("cook40", 1, 40, 1, 1, 0);
      door_open = 1'b1;
      step();
      check_outs("door_pause", 2, 40, 0, 1, 0);
      pulse(0, 0, 1, 0);
      check_val("door_start_st", 32'(state_o), 32'd2);
      check_val("door_start_mag", 32'(magnetron), 32'd0);
      door_open = 1'b0;
      step();
      pulse(0, 0, 1, 0);
      check_outs("resume", 1, 40, 1, 1, 0);
      pulse(0, 0, 0, 1);
      check_outs("stop1", 2, 40, 0, 1, 0);
      pulse(0, 0, 0, 1);
      check_outs("stop2", 0, 0, 0, 0, 0);

      // saturation
      for (int i = 0; i < 8; i++) pulse(0, 1, 0, 0);
      check_val("sat480", 32'(time_bin), 32'd480);
      pulse(0, 1, 0, 0);
      check_val("sat500", 32'(time_bin), 32'd500);
      pulse(0, 0, 1, 0);
      steps(20);
      check_val("t495", 32'(time_bin), 32'd495);
      steps(3);
      check_val("t495_hold", 32'(time_bin), 32'd495);
      pulse(1, 0, 0, 0);
      check_val("tick_add_sat", 32'(time_bin), 32'd500);
      check_val("tick_add_st", 32'(state_o), 32'd1);
      pulse(0, 0, 0, 1);
      pulse(0, 0, 0, 1);
      check_val("sat_cancel", 32'(time_bin), 32'd0);

      // stop during DONE
      pulse(0, 0, 1, 0);
      steps(120);
      check_val("done2_st", 32'(state_o), 32'd3);
      steps(2);
      check_val("done2_bz", 32'(buzzer), 32'd1);
      pulse(0, 0, 0, 1);
      check_outs("done_stop", 0, 0, 0, 0, 0);

      // reset mid-cook at 100 s, tick_cnt=2
      pulse(0, 1, 0, 0);
      for (int i = 0; i < 4; i++) pulse(1, 0, 0, 0);
      check_val("t100", 32'(time_bin), 32'd100);
      pulse(0, 0, 1, 0);
      steps(2);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check_outs("midrst", 0, 0, 0, 0, 0);
      pulse(1, 0, 0, 0);
      pulse(0, 0, 1, 0);
      steps(3);
      check_val("restart_hold", 32'(time_bin), 32'd10);
      steps(1);
      check_val("restart_tick", 32'(time_bin), 32'd9);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
